alu_share_arb: RTL and testbench
================================

# alu_share_arb

Round-robin arbiter and sequencer that shares the single-cycle `execute` ALU between `NUM_REQ` requesters (e.g. the core's integer path plus address-generation or debug units). Each requester issues an operation through a valid/ready handshake. The block latches the operands, drives the ALU for one cycle, registers the result and returns it through a per-requester valid/ready response channel. It sits between the requesters and the ALU instance and is the only driver of the ALU inputs.

## Interface
- `NUM_REQ`, 2, number of requesters; legal range 2..4.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous assert, active-low.
- `req_valid_i`  in  [NUM_REQ]  requester k has an operation pending.
- `req_ready_o`  out  [NUM_REQ]  operation k accepted this cycle.
- `req_opr_a_i`  in  [NUM_REQ][32]  operand A per requester.
- `req_opr_b_i`  in  [NUM_REQ][32]  operand B per requester.
- `req_op_i`  in  [NUM_REQ][4]  ALU operation select per requester, `riscv_pkg` encoding.
- `rsp_valid_o`  out  [NUM_REQ]  result for requester k available.
- `rsp_ready_i`  in  [NUM_REQ]  requester k consumes the result.
- `rsp_data_o`  out  32  result data, shared by all requesters; the owner is identified by `rsp_valid_o`.
- `alu_opr_a_o`  out  32  to ALU `opr_a_i`.
- `alu_opr_b_o`  out  32  to ALU `opr_b_i`.
- `alu_op_sel_o`  out  4  to ALU `op_sel_i`.
- `alu_res_i`  in  32  from ALU `alu_res_o` (combinational).
- `busy_o`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - If no `req_valid_i` bit is set, stay in IDLE.
  - Otherwise select the winner by round robin. Search from `last_q+1` upward, modulo `NUM_REQ`, and take the first set bit.
  - Assert `req_ready_o[winner]` combinationally; all other ready bits stay 0.
  - Latch the winner's `req_opr_a_i`, `req_opr_b_i` and `req_op_i` into `opa_q`, `opb_q` and `op_q`.
  - Set `owner_q` and `last_q` to the winner, then go to EXEC.
- **EXEC:**
  - `alu_*_o` are driven from `opa_q`, `opb_q` and `op_q`. They are driven from these registers in every state, so they are never driven directly from the requester inputs.
  - Capture `alu_res_i` into `res_q`, then go to RESP.
- **RESP:**
  - `rsp_valid_o[owner_q]` is 1 and `rsp_data_o` is `res_q`.
  - Hold both until `rsp_ready_i[owner_q]` is 1, then go to IDLE in the next cycle.
  - `rsp_ready_i` bits of other requesters are ignored.
- `req_ready_o` is 0 in EXEC and RESP. There is no acceptance in the same cycle as a response handshake.
- Handshake rules for requesters:
  - `req_valid_i` must not depend on `req_ready_o`.
  - Operands and op must stay stable while valid is high and ready is low.
  - Dropping valid before acceptance is permitted: the request is simply not arbitrated.
- Op codes are passed through without checking. An undefined code yields whatever the ALU returns, which is 0 for undefined codes.
- `rsp_data_o` equals `res_q` in all states. Consumers must qualify it with `rsp_valid_o`.

## Timing
- Reset values:
  - State is IDLE.
  - `opa_q`, `opb_q`, `op_q`, `res_q` and `owner_q` are 0.
  - `last_q` is `NUM_REQ-1`, so requester 0 wins first after reset.
  - All `req_ready_o`, `rsp_valid_o` and `busy_o` are 0; `rsp_data_o` and `alu_*_o` are 0.
- Cycle numbering for one transaction:
  - Acceptance happens in cycle N.
  - `alu_*_o` carry the operation in cycle N+1.
  - `rsp_valid_o` rises at the start of cycle N+2, giving a response latency of 2.
- Throughput with `rsp_ready_i` held high: one transaction per 3 cycles. The next acceptance is no earlier than cycle N+3.
- `busy_o` is 1 from cycle N+1 through the response handshake cycle inclusive.
- Arbitration:
  - Requester k, when continuously valid, waits at most `NUM_REQ-1` other transactions before it is granted.
  - A lone requester is granted on every acceptance opportunity.
- Backpressure: RESP holds indefinitely. `rsp_data_o` and `rsp_valid_o` stay stable, and new requests wait.
- Reset asserted mid-transaction:
  - All state clears immediately (asynchronous) and the in-flight transaction is dropped with no response.
  - After reset deassertion, the first edge observes IDLE.

## Test plan
- **Single request:** req0 issues ADD 5, 3 at cycle N. Required: `req_ready_o[0]`=1 in N; `alu_opr_a_o`=5, `alu_opr_b_o`=3 in N+1; `rsp_valid_o[0]`=1 with `rsp_data_o`=8 in N+2; `busy_o`=1 over N+1..N+2.
- **Simultaneous first requests after reset:** req0 SUB 10, 4 and req1 XOR 0xF0, 0xFF. Required: req0 served first with result 6; req1 accepted 3 cycles later with result 0x0F.
- **Fairness:** both requesters held valid for 6 transactions. Required: grants alternate 0,1,0,1,0,1 and no requester is starved.
- **Backpressure:** `rsp_ready_i[1]`=0 for 5 cycles during an SRA 0x80000000, 4 response. Required: `rsp_data_o`=0xF8000000 held stable, `rsp_valid_o[1]` stays high, and pending req0 gets no ready until the handshake completes.
- **Reset mid-op:** `rst_ni` low during EXEC. Required: all outputs 0 in the same cycle, no response issued, and the next request after release is granted to req0.
- **Signed/unsigned compare (SLTU vs SLT) with 0xFFFFFFFF, 1:**
  - SLTU returns 0.
  - SLT returns 1.
  - An undefined op code returns 0.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// Requester-side bus of the shared ALU sequencer: per-requester operation
// channel (valid/ready) plus per-requester response channel with shared data.
interface alu_share_arb_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0][31:0] req_opr_a_i;
  logic [NUM_REQ-1:0][31:0] req_opr_b_i;
  logic [NUM_REQ-1:0][3:0]  req_op_i;
  logic [NUM_REQ-1:0]       rsp_valid_o;
  logic [NUM_REQ-1:0]       rsp_ready_i;
  logic [31:0]              rsp_data_o;

  // Requesters drive operations and consume responses.
  modport master (
    output req_valid_i, req_opr_a_i, req_opr_b_i, req_op_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o
  );

  // The arbiter accepts operations and produces responses.
  modport slave (
    input  req_valid_i, req_opr_a_i, req_opr_b_i, req_op_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one single-cycle ALU among NUM_REQ
// requesters. One transaction at a time: IDLE (accept) -> EXEC (ALU) -> RESP.
module alu_share_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  alu_share_arb_if.slave bus,
  output logic [31:0] alu_opr_a_o,
  output logic [31:0] alu_opr_b_o,
  output logic [3:0]  alu_op_sel_o,
  input  logic [31:0] alu_res_i,
  output logic        busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [31:0]        opa_q, opa_d;
  logic [31:0]        opb_q, opb_d;
  logic [3:0]         op_q, op_d;
  logic [31:0]        res_q, res_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;

  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] grant;

  // Round-robin pick: scan from the requester after the last winner, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
      if (!found && bus.req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Ready is combinational to the winner, only in IDLE and never while in reset.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = rst_ni && (state_q == IDLE) && found &&
                         (winner == IDX_W'(gi));
    end
  endgenerate

  // Next-state and datapath register updates for the three-phase sequence.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    op_d        = op_q;
    res_d       = res_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          opa_d   = bus.req_opr_a_i[winner];
          opb_d   = bus.req_opr_b_i[winner];
          op_d    = bus.req_op_i[winner];
          owner_d = winner;
          last_d  = winner;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d       = alu_res_i;
        rsp_valid_d = NUM_REQ'(1) << owner_q;
        state_d     = RESP;
      end
      RESP: begin
        // Only the owner's ready completes the response.
        if (bus.rsp_ready_i[owner_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = '0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset clears everything at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(NUM_REQ - 1);
      owner_q     <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      op_q        <= '0;
      res_q       <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      op_q        <= op_d;
      res_q       <= res_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // ALU inputs come only from the latched operands, never from requesters.
  assign alu_opr_a_o     = opa_q;
  assign alu_opr_b_o     = opb_q;
  assign alu_op_sel_o    = op_q;
  assign bus.req_ready_o = grant;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = res_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with two requesters and a small ALU model.
module tb_alu_share_arb;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;
  logic        busy;
  int          n_total;
  int          n_bad;

  alu_share_arb_if #(.NUM_REQ(2)) bus ();

  alu_share_arb #(.NUM_REQ(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .alu_opr_a_o (alu_a),
    .alu_opr_b_o (alu_b),
    .alu_op_sel_o(alu_op),
    .alu_res_i   (alu_res),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-cycle ALU; undefined codes return 0.
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_res = alu_a + alu_b;
      OP_SUB:  alu_res = alu_a - alu_b;
      OP_SLL:  alu_res = alu_a << alu_b[4:0];
      OP_SLT:  alu_res = {31'b0, ($signed(alu_a) < $signed(alu_b))};
      OP_SLTU: alu_res = {31'b0, (alu_a < alu_b)};
      OP_XOR:  alu_res = alu_a ^ alu_b;
      OP_SRL:  alu_res = alu_a >> alu_b[4:0];
      OP_SRA:  alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      OP_OR:   alu_res = alu_a | alu_b;
      OP_AND:  alu_res = alu_a & alu_b;
      default: alu_res = 32'h0;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_valid_i[k] = 1'b1;
    bus.req_op_i[k]    = op;
    bus.req_opr_a_i[k] = a;
    bus.req_opr_b_i[k] = b;
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] vld,
                           input logic [31:0] data);
    check_val({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'(vld));
    check_val({tag, "_rsp_data"}, bus.rsp_data_o, data);
    $display("txn %s: rsp_valid=%b data=%08h", tag, bus.rsp_valid_o, bus.rsp_data_o);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    bus.req_valid_i = '0;
    bus.req_opr_a_i = '0;
    bus.req_opr_b_i = '0;
    bus.req_op_i    = '0;
    bus.rsp_ready_i = 2'b11;
    cyc();
    cyc();

    // Reset state
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_ready", 32'(bus.req_ready_o), 32'd0);
    check_val("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check_val("rst_rsp_data", bus.rsp_data_o, 32'd0);
    check_val("rst_alu_a", alu_a, 32'd0);
    check_val("rst_alu_b", alu_b, 32'd0);
    check_val("rst_alu_op", 32'(alu_op), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Single request: ADD 5,3 on req0
    set_req(0, OP_ADD, 32'd5, 32'd3);
    #1 check_val("t1_ready", 32'(bus.req_ready_o), 32'h1);
    cyc();
    bus.req_valid_i = '0;
    #1;
    check_val("t1_alu_a", alu_a, 32'd5);
    check_val("t1_alu_b", alu_b, 32'd3);
    check_val("t1_alu_op", 32'(alu_op), 32'(OP_ADD));
    check_val("t1_busy_n1", 32'(busy), 32'd1);
    check_val("t1_ready_exec", 32'(bus.req_ready_o), 32'd0);
    cyc();
    check_rsp("t1", 2'b01, 32'd8);
    check_val("t1_busy_n2", 32'(busy), 32'd1);
    cyc();
    check_val("t1_busy_after", 32'(busy), 32'd0);
    check_val("t1_rsp_after", 32'(bus.rsp_valid_o), 32'd0);

    // Simultaneous requests straight after reset: req0 first
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    set_req(0, OP_SUB, 32'd10, 32'd4);
    set_req(1, OP_XOR, 32'hF0, 32'hFF);
    #1 check_val("t2_ready0", 32'(bus.req_ready_o), 32'h1);
    cyc();
    bus.req_valid_i[0] = 1'b0;
    #1;
    check_val("t2_ready_exec", 32'(bus.req_ready_o), 32'd0);
    check_val("t2_alu_op", 32'(alu_op), 32'(OP_SUB));
    cyc();
    check_rsp("t2a", 2'b01, 32'd6);
    check_val("t2_ready_resp", 32'(bus.req_ready_o), 32'd0);
    cyc();
    check_val("t2_ready1", 32'(bus.req_ready_o), 32'h2);
    cyc();
    bus.req_valid_i[1] = 1'b0;
    #1 check_val("t2_alu_a", alu_a, 32'hF0);
    cyc();
    check_rsp("t2b", 2'b10, 32'h0F);
    cyc();

    // Fairness: both held valid for six transactions
    set_req(0, OP_ADD, 32'd1, 32'd1);
    set_req(1, OP_ADD, 32'd100, 32'd1);
    for (int t = 0; t < 6; t++) begin
      #1 check_val("t3_grant", 32'(bus.req_ready_o),
                   (t % 2 == 0) ? 32'h1 : 32'h2);
      cyc();
      cyc();
      check_rsp("t3", (t % 2 == 0) ? 2'b01 : 2'b10,
                (t % 2 == 0) ? 32'd2 : 32'd101);
      if (t == 5) bus.req_valid_i = '0;
      cyc();
    end

    // Backpressure on req1's SRA response while req0 waits
    set_req(1, OP_SRA, 32'h8000_0000, 32'd4);
    bus.rsp_ready_i = 2'b01;
    #1 check_val("t4_ready1", 32'(bus.req_ready_o), 32'h2);
    cyc();
    bus.req_valid_i = '0;
    set_req(0, OP_ADD, 32'd7, 32'd7);
    #1 check_val("t4_ready_exec", 32'(bus.req_ready_o), 32'd0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      check_rsp("t4_hold", 2'b10, 32'hF800_0000);
      check_val("t4_hold_ready", 32'(bus.req_ready_o), 32'd0);
      check_val("t4_hold_busy", 32'(busy), 32'd1);
      cyc();
    end
    bus.rsp_ready_i = 2'b11;
    #1 check_val("t4_hs_valid", 32'(bus.rsp_valid_o), 32'h2);
    cyc();
    check_val("t4_ready0", 32'(bus.req_ready_o), 32'h1);
    cyc();
    bus.req_valid_i[0] = 1'b0;
    cyc();
    check_rsp("t4b", 2'b01, 32'd14);
    cyc();

    // Reset during EXEC drops the transaction and restarts arbitration at req0
    set_req(0, OP_ADD, 32'd9, 32'd9);
    #1 check_val("t5_ready0", 32'(bus.req_ready_o), 32'h1);
    cyc();
    bus.req_valid_i[0] = 1'b0;
    #1 check_val("t5_alu_a_exec", alu_a, 32'd9);
    rst_n = 1'b0;
    set_req(0, OP_SLTU, 32'hFFFF_FFFF, 32'd1);
    set_req(1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
    #1;
    check_val("t5_rst_alu_a", alu_a, 32'd0);
    check_val("t5_rst_alu_op", 32'(alu_op), 32'd0);
    check_val("t5_rst_busy", 32'(busy), 32'd0);
    check_val("t5_rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check_val("t5_rst_ready", 32'(bus.req_ready_o), 32'd0);
    cyc();
    check_val("t5_rst_rsp_valid2", 32'(bus.rsp_valid_o), 32'd0);
    rst_n = 1'b1;
    #1 check_val("t5_post_ready", 32'(bus.req_ready_o), 32'h1);
    cyc();

    // SLTU / SLT / undefined op
    bus.req_valid_i[0] = 1'b0;
    #1;
    check_val("t6_rsp_exec", 32'(bus.rsp_valid_o), 32'd0);
    check_val("t6_alu_op", 32'(alu_op), 32'(OP_SLTU));
    cyc();
    check_rsp("t6_sltu", 2'b01, 32'd0);
    cyc();
    check_val("t6_ready1", 32'(bus.req_ready_o), 32'h2);
    cyc();
    bus.req_valid_i[1] = 1'b0;
    cyc();
    check_rsp("t6_slt", 2'b10, 32'd1);
    cyc();
    set_req(0, 4'hF, 32'd5, 32'd3);
    #1 check_val("t6_ready_undef", 32'(bus.req_ready_o), 32'h1);
    cyc();
    bus.req_valid_i[0] = 1'b0;
    #1 check_val("t6_alu_op_undef", 32'(alu_op), 32'hF);
    cyc();
    check_rsp("t6_undef", 2'b01, 32'd0);
    cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
